// File: rtl/shiftadd_pkg.sv
// Shared types and defaults for the shift-and-add multiplier family.
// Reused by the combinational multiplier, the sequential controller and the benches.
package shiftadd_pkg;

    localparam int unsigned DefaultN = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/shiftadd_dp.sv
// Shift-and-add datapath: accumulator, shifting multiplicand and multiplier, one shared adder.
// load_i captures fresh operands; step_i performs one multiply step.
module shiftadd_dp #(
    parameter int unsigned N = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   x_i,
    input  logic [N-1:0]   y_i,
    output logic [2*N-1:0] acc_nxt_o
);

    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_step;

    // Accumulator value after the current step; the controller latches it on the last step.
    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign acc_nxt_o = acc_step;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, x_i};
            mplier_d = y_i;
        end else if (step_i) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/shiftadd_seq_ctrl.sv
// Sequential N-cycle unsigned multiplier controller with start/done handshake.
// Holds the FSM, step counter and registered product; drives the datapath load/step.
module shiftadd_seq_ctrl
    import shiftadd_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] s
);

    localparam int unsigned CW = $clog2(N + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*N-1:0] s_q, s_d;
    logic           load;
    logic           step;
    logic [2*N-1:0] acc_nxt;

    shiftadd_dp #(
        .N (N)
    ) u_dp (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (load),
        .step_i    (step),
        .x_i       (x),
        .y_i       (y),
        .acc_nxt_o (acc_nxt)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        s_d     = s_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                step    = 1'b1;
                count_d = count_q + CW'(1);
                // Fixed latency: no early exit when the multiplier runs out of ones.
                if (count_q == CW'(N - 1)) begin
                    s_d     = acc_nxt;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            s_q     <= s_d;
        end
    end

    assign busy = (state_q == StCalc);
    assign done = (state_q == StDone);
    assign s    = s_q;

endmodule

// File: tb/tb_shiftadd_seq_ctrl.sv
// Directed bench for shiftadd_seq_ctrl: handshake timing, boundaries, back-to-back,
// mid-run reset and an exhaustive sweep against a shift-and-add reference.
module tb_shiftadd_seq_ctrl;
    import shiftadd_pkg::*;

    localparam int unsigned N = DefaultN;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*N-1:0] s;

    int n_cmp;
    int n_err;

    shiftadd_seq_ctrl #(
        .N (N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] acc;
        acc = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (b[k]) acc = acc + ({{N{1'b0}}, a} << k);
        end
        return acc;
    endfunction

    // One isolated multiply; operands are scrambled right after the accepting edge.
    task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input string tag, input bit detailed);
        @(negedge clk);
        start = 1'b1;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = N'($urandom);
        y     = N'($urandom);
        for (int k = 0; k < int'(N); k++) begin
            @(negedge clk);
            if (detailed) begin
                check_eq({tag, "_busy"}, 32'(busy), 32'd1);
                check_eq({tag, "_nodone"}, 32'(done), 32'd0);
            end
        end
        @(negedge clk);
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_s"}, 32'(s), 32'(exp));
        if (detailed) begin
            check_eq({tag, "_busy_lo"}, 32'(busy), 32'd0);
            @(negedge clk);
            check_eq({tag, "_done_1cyc"}, 32'(done), 32'd0);
            check_eq({tag, "_s_hold"}, 32'(s), 32'(exp));
        end
    endtask

    logic [N-1:0]   bb_x [3];
    logic [N-1:0]   bb_y [3];
    logic [2*N-1:0] bb_s [3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_s", 32'(s), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full-scale operands: no truncation.
        do_mul(4'd15, 4'd15, 8'd225, "max", 1'b1);

        // Zero operands still take the full latency.
        do_mul(4'd0, 4'd9, 8'd0, "x0", 1'b1);
        do_mul(4'd9, 4'd0, 8'd0, "y0", 1'b1);

        // Back-to-back with start held high.
        bb_x[0] = 4'd3;  bb_y[0] = 4'd5;  bb_s[0] = 8'd15;
        bb_x[1] = 4'd7;  bb_y[1] = 4'd1;  bb_s[1] = 8'd7;
        bb_x[2] = 4'd12; bb_y[2] = 4'd11; bb_s[2] = 8'd132;
        @(negedge clk);
        start = 1'b1;
        x     = bb_x[0];
        y     = bb_y[0];
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            if (p < 2) begin
                x = bb_x[p+1];
                y = bb_y[p+1];
            end else begin
                start = 1'b0;
            end
            for (int k = 0; k < int'(N); k++) begin
                @(negedge clk);
                check_eq($sformatf("b2b%0d_busy", p), 32'(busy), 32'd1);
                check_eq($sformatf("b2b%0d_nodone", p), 32'(done), 32'd0);
            end
            @(negedge clk);
            check_eq($sformatf("b2b%0d_done", p), 32'(done), 32'd1);
            check_eq($sformatf("b2b%0d_s", p), 32'(s), 32'(bb_s[p]));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_eq("b2b_end_done", 32'(done), 32'd0);
        check_eq("b2b_end_busy", 32'(busy), 32'd0);

        // start while busy is ignored.
        @(negedge clk);
        start = 1'b1;
        x     = 4'd13;
        y     = 4'd6;
        @(posedge clk);
        #1;
        x = 4'd2;
        y = 4'd2;
        for (int k = 0; k < int'(N); k++) begin
            @(negedge clk);
            check_eq("ign_busy", 32'(busy), 32'd1);
            check_eq("ign_nodone", 32'(done), 32'd0);
            if (k == 2) begin
                start = 1'b0;
                x     = '0;
                y     = '0;
            end
        end
        @(negedge clk);
        check_eq("ign_done", 32'(done), 32'd1);
        check_eq("ign_s", 32'(s), 32'd78);
        @(negedge clk);
        check_eq("ign_no_extra", 32'(done), 32'd0);
        check_eq("ign_idle", 32'(busy), 32'd0);

        // Asynchronous reset two cycles into a run.
        @(negedge clk);
        start = 1'b1;
        x     = 4'd15;
        y     = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_s", 32'(s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("post_rst_done", 32'(done), 32'd0);
            check_eq("post_rst_busy", 32'(busy), 32'd0);
            check_eq("post_rst_s", 32'(s), 32'd0);
        end

        // Exhaustive sweep.
        for (int i = 0; i < (1 << N); i++) begin
            for (int j = 0; j < (1 << N); j++) begin
                do_mul(N'(i), N'(j), ref_mul(N'(i), N'(j)),
                       $sformatf("sweep_%0dx%0d", i, j), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
